// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;
  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready holding register for the fetched instruction and its pc.
module fetch_slot
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [31:0]     next_instr,
  input  logic [XLEN-1:0] next_pc,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  // Load wins over drain; flush only drops the valid bit, payload is don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= next_instr;
      pc    <= next_pc;
    end else if (flush || (valid && ready)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Owns the PC, reads instruction memory and hands words to decode over valid/ready,
// with branch redirects, end-of-memory halt and sticky misaligned-target faults.
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'd0,
  parameter int unsigned     MEM_BYTES = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] Inst_Address,
  input  logic [31:0]     Instruction,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            halted,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [31:0]     fetch_count
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN:0]   fetch_end;
  logic            beyond_mem;
  logic            accept;
  logic            slot_free;
  logic            redirect;
  logic            misaligned;
  logic            fetch_go;
  logic            slot_flush;

  assign Inst_Address = pc;

  // The extra top bit keeps a pc near 2^64 from wrapping past the bound check.
  assign fetch_end  = {1'b0, pc} + (XLEN+1)'(INSTR_BYTES);
  assign beyond_mem = fetch_end > (XLEN+1)'(MEM_BYTES);

  assign accept     = if_valid && if_ready;
  assign slot_free  = !if_valid || if_ready;
  assign redirect   = branch_valid && (state != FAULT);
  assign misaligned = branch_target[1:0] != 2'b00;
  assign fetch_go   = (state == FETCH) && !redirect && slot_free && !beyond_mem;
  assign slot_flush = redirect || (state == FAULT);

  fetch_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (fetch_go),
    .flush      (slot_flush),
    .ready      (if_ready),
    .next_instr (Instruction),
    .next_pc    (pc),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (redirect) begin
      if (misaligned) begin
        state      <= FAULT;
        fault      <= 1'b1;
        fault_addr <= branch_target;
      end else begin
        state  <= FETCH;
        pc     <= branch_target;
        halted <= 1'b0;
      end
    end else if (state == FETCH && slot_free) begin
      if (beyond_mem) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        pc <= pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  // Handshakes completing on a redirect edge still count as delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (accept && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller with a scoreboard of expected deliveries.
module tb_instruction_fetch_controller;
  localparam logic [31:0] W0 = 32'h0285_3483;
  localparam logic [31:0] W1 = 32'h008A_8433;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        branch_valid;
  logic [63:0] branch_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
  logic        fault;
  logic [63:0] fault_addr;
  logic [31:0] fetch_count;

  logic [31:0] image [0:3];
  sb_entry_t   exp_q [$];
  int          checks;
  int          failures;

  instruction_fetch_controller #(
    .RESET_PC  (64'd0),
    .MEM_BYTES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Inst_Address  (Inst_Address),
    .Instruction   (Instruction),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .halted        (halted),
    .fault         (fault),
    .fault_addr    (fault_addr),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    Instruction = 32'h0;
    if (Inst_Address < 64'd16) Instruction = image[Inst_Address[3:2]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    sb_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Handshakes are sampled on the falling edge, ahead of the edge that completes them.
  task automatic tick();
    sb_entry_t e;
    @(negedge clk);
    if (if_valid && if_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("accept_pc", if_pc, e.pc);
        check("accept_instr", 64'(if_instr), 64'(e.instr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, Inst_Address, 64'd0);
    check({tag, "_valid"}, 64'(if_valid), 64'd0);
    check({tag, "_instr"}, 64'(if_instr), 64'd0);
    check({tag, "_pc"}, if_pc, 64'd0);
    check({tag, "_halted"}, 64'(halted), 64'd0);
    check({tag, "_fault"}, 64'(fault), 64'd0);
    check({tag, "_fault_addr"}, fault_addr, 64'd0);
    check({tag, "_count"}, 64'(fetch_count), 64'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    image[0]      = W0;
    image[1]      = W1;
    image[2]      = 32'h0;
    image[3]      = 32'h0;
    reset         = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 64'd0;
    if_ready      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Full stream to end of memory
    if_ready = 1'b1;
    push(64'd0, W0);
    push(64'd4, W1);
    push(64'd8, 32'h0);
    push(64'd12, 32'h0);
    repeat (5) tick();
    check("run_halted", 64'(halted), 64'd1);
    check("run_valid", 64'(if_valid), 64'd0);
    check("run_count", 64'(fetch_count), 64'd4);
    check("run_addr", Inst_Address, 64'd16);
    check("run_sb_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();
    check("halt_stays", 64'(halted), 64'd1);
    check("halt_no_fetch", 64'(if_valid), 64'd0);

    // Redirect out of HALT, then stall with slot full
    if_ready      = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 64'd0;
    tick();
    branch_valid = 1'b0;
    check("unhalt_halted", 64'(halted), 64'd0);
    check("unhalt_penalty", 64'(if_valid), 64'd0);
    tick();
    check("unhalt_valid", 64'(if_valid), 64'd1);
    check("unhalt_pc", if_pc, 64'd0);
    check("unhalt_instr", 64'(if_instr), 64'(W0));
    check("unhalt_addr", Inst_Address, 64'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_addr", Inst_Address, 64'd4);
      check("stall_pc", if_pc, 64'd0);
      check("stall_valid", 64'(if_valid), 64'd1);
    end
    push(64'd0, W0);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    check("resume_pc", if_pc, 64'd4);
    check("resume_count", 64'(fetch_count), 64'd5);

    // Redirect drops a held, unaccepted instruction
    branch_valid  = 1'b1;
    branch_target = 64'd4;
    tick();
    branch_valid = 1'b0;
    check("redir_flush", 64'(if_valid), 64'd0);
    check("redir_count", 64'(fetch_count), 64'd5);
    check("redir_addr", Inst_Address, 64'd4);
    tick();
    check("redir_pc", if_pc, 64'd4);
    check("redir_instr", 64'(if_instr), 64'(W1));
    check("redir_next_addr", Inst_Address, 64'd8);
    push(64'd4, W1);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    check("redir_after_count", 64'(fetch_count), 64'd6);
    check("redir_after_pc", if_pc, 64'd8);

    // Asynchronous reset between edges while stalled
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(64'd0, W0);
    if_ready = 1'b1;
    tick();
    tick();
    if_ready = 1'b0;
    check("restart_pc", if_pc, 64'd4);
    check("restart_count", 64'(fetch_count), 64'd1);

    // Misaligned redirect faults and locks out later redirects
    branch_valid  = 1'b1;
    branch_target = 64'd6;
    tick();
    branch_valid = 1'b0;
    check("fault_flag", 64'(fault), 64'd1);
    check("fault_addr", fault_addr, 64'd6);
    check("fault_valid", 64'(if_valid), 64'd0);
    check("fault_pc_held", Inst_Address, 64'd8);
    check("fault_count", 64'(fetch_count), 64'd1);
    branch_valid  = 1'b1;
    branch_target = 64'd0;
    if_ready      = 1'b1;
    tick();
    tick();
    branch_valid = 1'b0;
    check("fault_sticky", 64'(fault), 64'd1);
    check("fault_ignore_redir", Inst_Address, 64'd8);
    check("fault_still_empty", 64'(if_valid), 64'd0);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
